motor_relu_seq_ctrl: RTL and testbench

//  Sequencer for the ReLU activation stage of the motor MPC network (ap_fixed<16,7>).

---
 rtl/motor_relu_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_motor_relu_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_relu_seq_ctrl.sv
// ReLU sequencer for the motor MPC network: one shared ReLU lane
// walks a captured vector and publishes the result with an ap_done strobe.
module motor_relu_seq_ctrl #(
    parameter int N_ELEM = 3,
    parameter int W = 16,
    localparam int CNT_W = $clog2(N_ELEM + 1)
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_idle,
    output logic                ap_done,
    input  logic [N_ELEM*W-1:0] p_read,
    output logic [N_ELEM*W-1:0] ap_return,
    output logic [CNT_W-1:0]    pos_count
);

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [W-1:0]     in_buf [N_ELEM];
    logic [W-1:0]     shadow [N_ELEM];
    logic [W-1:0]     shadow_nxt [N_ELEM];
    logic [W-1:0]     cur_x;
    logic [W-1:0]     cur_y;
    logic             cur_pos;
    logic             last;
    logic             accept;

    // Handshake outputs decoded straight from the state.
    always_comb begin
        accept   = ap_start && (state == S_IDLE || state == S_DONE);
        ap_ready = accept;
        ap_idle  = (state == S_IDLE);
        ap_done  = (state == S_DONE);
    end

    // Shared ReLU lane: positive means sign clear and nonzero.
    always_comb begin
        cur_x   = in_buf[idx];
        cur_pos = !cur_x[W-1] && (|cur_x[W-2:0]);
        cur_y   = cur_pos ? {1'b0, cur_x[W-2:0]} : '0;
        cnt_nxt = cnt + CNT_W'(cur_pos);
        last    = (idx == IDX_LAST);
    end

    // Shadow with the current lane result merged in, so the final
    // element is visible on the same edge the result is published.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[idx] = cur_y;
    end

    // Control FSM: index walk and running positive count.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state <= S_RUN;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt_nxt;
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (ap_start) begin
                        state <= S_RUN;
                        idx   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Input capture on accept and per-element shadow fill during RUN.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                in_buf[i] <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < N_ELEM; i++) begin
                    in_buf[i] <= p_read[i*W +: W];
                end
            end
            if (state == S_RUN) begin
                shadow <= shadow_nxt;
            end
        end
    end

    // Published result, updated only when a vector finishes.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ap_return <= '0;
            pos_count <= '0;
        end else if (state == S_RUN && last) begin
            for (int i = 0; i < N_ELEM; i++) begin
                ap_return[i*W +: W] <= shadow_nxt[i];
            end
            pos_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_motor_relu_seq_ctrl.sv
// Randomized scoreboard bench for motor_relu_seq_ctrl.
// Expected results come from plain arithmetic on the accepted vector.
module tb_motor_relu_seq_ctrl;

    localparam int N = 3;
    localparam int W = 16;
    localparam int CW = $clog2(N + 1);

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           ap_start = 1'b0;
    logic           ap_ready;
    logic           ap_idle;
    logic           ap_done;
    logic [N*W-1:0] p_read = '0;
    logic [N*W-1:0] ap_return;
    logic [CW-1:0]  pos_count;

    motor_relu_seq_ctrl #(.N_ELEM(N), .W(W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_ready  (ap_ready),
        .ap_idle   (ap_idle),
        .ap_done   (ap_done),
        .p_read    (p_read),
        .ap_return (ap_return),
        .pos_count (pos_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [N*W-1:0] ret;
        int             cnt;
        int             due;
    } exp_t;

    exp_t           q[$];
    exp_t           e;
    int             cyc = 0;
    int             la = -1000;
    int             d;
    bit             busy;
    bit             dn;
    bit             acc;
    int             ncmp = 0;
    int             nfail = 0;
    logic [N*W-1:0] last_ret = '0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [N*W-1:0] v, input int due);
        exp_t r;
        logic [W-1:0] x;
        r.ret = '0;
        r.cnt = 0;
        r.due = due;
        for (int i = 0; i < N; i++) begin
            x = v[i*W +: W];
            if ($signed(x) > 0) begin
                r.ret[i*W +: W] = x;
                r.cnt++;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] pick_elem();
        case ($urandom % 6)
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [N*W-1:0] pick_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = pick_elem();
        return v;
    endfunction

    always @(posedge ap_clk) cyc++;

    // Stimulus-side model: acceptance timing derived from last accept cycle.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            d    = cyc - la;
            busy = (d >= 1) && (d <= N);
            dn   = (d == N + 1);
            acc  = ap_start && !busy;
            check("ap_ready", 64'(ap_ready), 64'(acc));
            check("ap_idle", 64'(ap_idle), 64'(!busy && !dn));
            if (acc) begin
                q.push_back(model(p_read, cyc + N + 1));
                la = cyc;
            end
        end
    end

    // Monitor: pop on ap_done, otherwise check result stability.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (ap_done) begin
                check("pending_on_done", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("ap_return", 64'(ap_return), 64'(e.ret));
                    check("pos_count", 64'(pos_count), 64'(e.cnt));
                    last_ret = e.ret;
                end
            end else begin
                check("ret_stable", 64'(ap_return), 64'(last_ret));
                if (q.size() > 0 && q[0].due < cyc) begin
                    check("done_by_due", 64'(cyc), 64'(q[0].due));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic one_vec(input logic [N*W-1:0] v);
        ap_start = 1'b1;
        p_read   = v;
        step();
        ap_start = 1'b0;
        p_read   = pick_vec();
    endtask

    initial begin
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        #1;
        check("rst_idle", 64'(ap_idle), 64'(1));
        check("rst_done", 64'(ap_done), 64'(0));
        check("rst_ready", 64'(ap_ready), 64'(0));
        check("rst_return", 64'(ap_return), 64'(0));
        check("rst_count", 64'(pos_count), 64'(0));

        step();
        one_vec({16'h0100, 16'hFF00, 16'h0000});
        repeat (5) step();
        check("t2_return", 64'(ap_return), 64'(48'h0100_0000_0000));
        check("t2_count", 64'(pos_count), 64'(1));

        one_vec({16'h7FFF, 16'h8000, 16'h0001});
        repeat (5) step();
        check("t3_return", 64'(ap_return), 64'(48'h7FFF_0000_0001));
        check("t3_count", 64'(pos_count), 64'(2));

        ap_start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            p_read = pick_vec();
            step();
        end
        ap_start = 1'b0;
        repeat (6) step();

        p_read = pick_vec();
        p_read[W-1:0] = 16'h0123;
        ap_start = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            p_read = pick_vec();
            step();
        end
        ap_start = 1'b0;
        repeat (6) step();

        one_vec(pick_vec());
        step();
        q.delete();
        ap_rst = 1'b1;
        #1;
        check("t6_return", 64'(ap_return), 64'(0));
        check("t6_count", 64'(pos_count), 64'(0));
        check("t6_done", 64'(ap_done), 64'(0));
        check("t6_idle", 64'(ap_idle), 64'(1));
        step();
        ap_rst = 1'b0;
        last_ret = '0;
        la = -1000;
        step();
        one_vec({16'h0005, 16'hFFFF, 16'h1234});
        repeat (5) step();
        check("t6_after", 64'(ap_return), 64'(48'h0005_0000_1234));

        for (int i = 0; i < 400; i++) begin
            ap_start = 1'($urandom % 2);
            p_read   = pick_vec();
            step();
        end
        ap_start = 1'b0;
        repeat (10) step();
        check("queue_drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
